// File: rtl/reduct_pkg.sv
// Shared types and elaboration helpers for the registered bitwise reduction tree.
package reduct_pkg;

    typedef enum logic [1:0] {
        OP_AND,
        OP_OR,
        OP_XOR
    } reduct_op_t;

    function automatic bit op_str_ok(input string s);
        return (s == "and") || (s == "or") || (s == "xor");
    endfunction

    // Unknown strings are rejected in reduct_pipe via op_str_ok.
    function automatic reduct_op_t op_from_str(input string s);
        if (s == "and") return OP_AND;
        if (s == "xor") return OP_XOR;
        return OP_OR;
    endfunction

    // ceil(log2(n)); 0 for n <= 1.
    function automatic int unsigned calc_lvl(input int unsigned n);
        int unsigned l;
        l = 0;
        while ((l < 31) && ((32'd1 << l) < n)) l++;
        return l;
    endfunction

    // Words remaining after l levels of pairwise combining.
    function automatic int unsigned words_at(input int unsigned n, input int unsigned l);
        int unsigned r;
        r = n;
        for (int unsigned i = 0; i < l; i++) r = (r + 1) / 2;
        return r;
    endfunction

endpackage

// File: rtl/reduct_level.sv
// One tree level: combines adjacent word pairs, an odd leftover word passes through.
module reduct_level
    import reduct_pkg::*;
#(
    parameter int unsigned N    = 2,
    parameter int unsigned DATA = 16,
    parameter reduct_op_t  OP   = OP_OR
) (
    input  logic [N-1:0][DATA-1:0]         in_i,
    output logic [(N+1)/2-1:0][DATA-1:0]   out_o
);

    for (genvar i = 0; i < N / 2; i++) begin : g_pair
        assign out_o[i] = (OP == OP_AND) ? (in_i[2*i] & in_i[2*i+1]) :
                          (OP == OP_OR)  ? (in_i[2*i] | in_i[2*i+1]) :
                                           (in_i[2*i] ^ in_i[2*i+1]);
    end

    if (N % 2 == 1) begin : g_odd
        assign out_o[N/2] = in_i[N-1];
    end

endmodule

// File: rtl/reduct_pipe.sv
// Registered IN-word bitwise AND/OR/XOR reduction with optional inversion.
// Define REDUCT_PIPE_EN to register every tree level (latency LVL+1 instead of 1).
module reduct_pipe
    import reduct_pkg::*;
#(
    parameter string       OPE  = "or",
    parameter int unsigned NOT  = 0,
    parameter int unsigned IN   = 4,
    parameter int unsigned DATA = 16
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     in_valid,
    input  logic [IN-1:0][DATA-1:0]  in,
    output logic                     out_valid,
    output logic [DATA-1:0]          out
);

    localparam reduct_op_t  Op  = op_from_str(OPE);
    localparam int unsigned Lvl = calc_lvl(IN);

    if (!op_str_ok(OPE)) begin : g_bad_ope
        $error("reduct_pipe: OPE must be \"and\", \"or\" or \"xor\"");
    end
    if (IN < 1 || DATA < 1) begin : g_bad_size
        $error("reduct_pipe: IN and DATA must be >= 1");
    end

    for (genvar l = 0; l < Lvl; l++) begin : g_lvl
        localparam int unsigned NI = words_at(IN, l);
        localparam int unsigned NO = words_at(IN, l + 1);

        logic [NI-1:0][DATA-1:0] d_in;
        logic                    v_in;
        logic [NO-1:0][DATA-1:0] d_comb;
        logic [NO-1:0][DATA-1:0] d_out;
        logic                    v_out;

        if (l == 0) begin : g_first
            assign d_in = in;
            assign v_in = in_valid;
        end else begin : g_next
            assign d_in = g_lvl[l-1].d_out;
            assign v_in = g_lvl[l-1].v_out;
        end

        reduct_level #(
            .N    (NI),
            .DATA (DATA),
            .OP   (Op)
        ) u_level (
            .in_i  (d_in),
            .out_o (d_comb)
        );

`ifdef REDUCT_PIPE_EN
        logic [NO-1:0][DATA-1:0] stage_q;
        logic                    stage_v_q;

        always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
                stage_q   <= '0;
                stage_v_q <= 1'b0;
            end else begin
                stage_q   <= d_comb;
                stage_v_q <= v_in;
            end
        end

        assign d_out = stage_q;
        assign v_out = stage_v_q;
`else
        assign d_out = d_comb;
        assign v_out = v_in;
`endif
    end

    logic [DATA-1:0] tree_d;
    logic            tree_v;

    if (Lvl == 0) begin : g_flat
        assign tree_d = in[0];
        assign tree_v = in_valid;
    end else begin : g_tree
        assign tree_d = g_lvl[Lvl-1].d_out[0];
        assign tree_v = g_lvl[Lvl-1].v_out;
    end

    logic [DATA-1:0] out_d, out_q;
    logic            out_valid_q;

    // Inversion sits after the tree only, so reset still yields out == 0.
    always_comb begin
        out_d = tree_d;
        if (NOT != 0) out_d = ~tree_d;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= tree_v;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_reduct_pipe.sv
// Scoreboard bench for reduct_pipe: eight instances (all OPE x NOT at IN=4, plus IN=1 and IN=5)
// share one stimulus stream; a monitor checks each output against a plain-arithmetic model.
module tb_reduct_pipe;

    typedef struct {
        int unsigned due;
        logic [15:0] val;
    } item_t;

    logic              clk;
    logic              reset_;
    logic              in_valid;
    logic [4:0][15:0]  in5;
    logic [15:0]       o_all [8];
    logic              v_all [8];

    // 0=and 1=or 2=xor
    int cfg_op  [8] = '{0, 0, 1, 1, 2, 2, 0, 2};
    int cfg_not [8] = '{0, 1, 0, 1, 0, 1, 1, 0};
    int cfg_in  [8] = '{4, 4, 4, 4, 4, 4, 1, 5};
`ifdef REDUCT_PIPE_EN
    int lat     [8] = '{3, 3, 3, 3, 3, 3, 1, 4};
`else
    int lat     [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif

    item_t       sb [8][$];
    int unsigned edge_n = 0;
    int          n_chk  = 0;
    int          n_err  = 0;

    reduct_pipe #(.OPE("and"), .NOT(0), .IN(4), .DATA(16)) u_and0 (
        .clk(clk), .reset_(reset_), .in_valid(in_valid), .in(in5[3:0]),
        .out_valid(v_all[0]), .out(o_all[0]));
    reduct_pipe #(.OPE("and"), .NOT(1), .IN(4), .DATA(16)) u_and1 (
        .clk(clk), .reset_(reset_), .in_valid(in_valid), .in(in5[3:0]),
        .out_valid(v_all[1]), .out(o_all[1]));
    reduct_pipe #(.OPE("or"), .NOT(0), .IN(4), .DATA(16)) u_or0 (
        .clk(clk), .reset_(reset_), .in_valid(in_valid), .in(in5[3:0]),
        .out_valid(v_all[2]), .out(o_all[2]));
    reduct_pipe #(.OPE("or"), .NOT(1), .IN(4), .DATA(16)) u_or1 (
        .clk(clk), .reset_(reset_), .in_valid(in_valid), .in(in5[3:0]),
        .out_valid(v_all[3]), .out(o_all[3]));
    reduct_pipe #(.OPE("xor"), .NOT(0), .IN(4), .DATA(16)) u_xor0 (
        .clk(clk), .reset_(reset_), .in_valid(in_valid), .in(in5[3:0]),
        .out_valid(v_all[4]), .out(o_all[4]));
    reduct_pipe #(.OPE("xor"), .NOT(1), .IN(4), .DATA(16)) u_xor1 (
        .clk(clk), .reset_(reset_), .in_valid(in_valid), .in(in5[3:0]),
        .out_valid(v_all[5]), .out(o_all[5]));
    reduct_pipe #(.OPE("and"), .NOT(1), .IN(1), .DATA(16)) u_in1 (
        .clk(clk), .reset_(reset_), .in_valid(in_valid), .in(in5[0:0]),
        .out_valid(v_all[6]), .out(o_all[6]));
    reduct_pipe #(.OPE("xor"), .NOT(0), .IN(5), .DATA(16)) u_in5 (
        .clk(clk), .reset_(reset_), .in_valid(in_valid), .in(in5),
        .out_valid(v_all[7]), .out(o_all[7]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n++;

    function automatic logic [15:0] model(input int op, input int nt, input int n,
                                          input logic [4:0][15:0] w);
        logic [15:0] r;
        r = w[0];
        for (int i = 1; i < n; i++) begin
            case (op)
                0:       r = r & w[i];
                1:       r = r | w[i];
                default: r = r ^ w[i];
            endcase
        end
        if (nt != 0) r = ~r;
        return r;
    endfunction

    task automatic send(input logic [4:0][15:0] v, input logic vld);
        item_t it;
        @(negedge clk);
        #1;
        in5      = v;
        in_valid = vld;
        if (vld) begin
            for (int d = 0; d < 8; d++) begin
                it.due = edge_n + lat[d];
                it.val = model(cfg_op[d], cfg_not[d], cfg_in[d], v);
                sb[d].push_back(it);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 8; d++) begin
            n_chk++;
            if (o_all[d] !== 16'h0 || v_all[d] !== 1'b0) begin
                n_err++;
                $display("FAIL %s dut%0d: got out=%h valid=%b want out=0000 valid=0",
                         tag, d, o_all[d], v_all[d]);
            end
        end
    endtask

    // Monitor: an entry is due exactly on its edge; out_valid must match that.
    always @(negedge clk) begin
        if (!reset_) begin
            check_zero("reset_hold");
        end else begin
            for (int d = 0; d < 8; d++) begin
                item_t it;
                bit    ev;
                ev = (sb[d].size() > 0) && (sb[d][0].due == edge_n);
                n_chk++;
                if (v_all[d] !== ev) begin
                    n_err++;
                    $display("FAIL out_valid dut%0d edge %0d: got %b want %b",
                             d, edge_n, v_all[d], ev);
                end
                if (ev) begin
                    it = sb[d].pop_front();
                    n_chk++;
                    if (o_all[d] !== it.val) begin
                        n_err++;
                        $display("FAIL out dut%0d edge %0d: got %h want %h",
                                 d, edge_n, o_all[d], it.val);
                    end
                end
                while (sb[d].size() > 0 && sb[d][0].due < edge_n) begin
                    it = sb[d].pop_front();
                    n_chk++;
                    n_err++;
                    $display("FAIL missing dut%0d due %0d: got nothing want %h",
                             d, it.due, it.val);
                end
            end
        end
    end

    initial begin
        logic [4:0][15:0] v;
        logic             pat [5];

        reset_   = 1'b0;
        in_valid = 1'b0;
        in5      = '0;
        repeat (3) @(negedge clk);
        #1;
        reset_ = 1'b1;

        v = {16'h1234, 16'h1000, 16'h0100, 16'h0010, 16'h0001};
        send(v, 1'b1);
        v = {16'h0F0F, 16'hFFFF, 16'hF0FF, 16'hFF0F, 16'hFFFF};
        send(v, 1'b1);
        v = {16'h8000, 16'h0001, 16'hFFFF, 16'h5555, 16'hAAAA};
        send(v, 1'b1);

        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 5; k++) v[k] = 16'($urandom);
            send(v, pat[i]);
        end
        v = '0;
        repeat (4) send(v, 1'b0);

        // Reset mid-stream: in-flight entries are discarded.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 5; k++) v[k] = 16'($urandom);
            send(v, 1'b1);
        end
        @(posedge clk);
        #2;
        reset_   = 1'b0;
        in_valid = 1'b0;
        for (int d = 0; d < 8; d++) sb[d].delete();
        #1;
        check_zero("reset_assert");
        repeat (2) @(negedge clk);
        #1;
        reset_ = 1'b1;
        v = '0;
        repeat (5) send(v, 1'b0);

        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 5; k++) v[k] = 16'($urandom);
            send(v, 1'($urandom_range(0, 3) != 0));
        end
        v = '0;
        repeat (8) send(v, 1'b0);

        for (int d = 0; d < 8; d++) begin
            n_chk++;
            if (sb[d].size() != 0) begin
                n_err++;
                $display("FAIL drain dut%0d: got %0d pending want 0", d, sb[d].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
